// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and types for the regfile writeback arbiter.
// No logic; constants and the request struct only.
// Types carry no flow control of their own.
package rf_wb_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int RFIDX_WIDTH   = 5;
    localparam int RFREG_NUM     = 32;
    localparam int WB_STARVE_MAX = 4;

    // Width of the starvation counter; holds STARVE_MAX values 1..15
    localparam int STARVE_CNT_W  = 4;

    // One writeback request: destination register and its data
    typedef struct packed {
        logic [RFIDX_WIDTH-1:0] idx;
        logic [XLEN-1:0]        data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_starve_ctr.sv
// Saturating count of cycles port 1 has been refused; raises starve at the limit.
// Latency: starve is combinational from v1 and the registered count.
// Backpressure: counts only while v1 is held without rdy1; clears on grant or on idle.
module rf_wb_starve_ctr
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic clk,
    input  logic rstn,
    input  logic v1,
    input  logic rdy1,
    output logic starve
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt;

    // Count refused cycles, saturating; any grant or a dropped request starts over
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!v1 || rdy1) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + STARVE_CNT_W'(1);
        end
    end

    assign starve = v1 & (cnt == CNT_MAX);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between the WB stage (port 0) and the long-latency unit (port 1).
// Latency: accept in cycle N drives we3/wa3/wd3 in cycle N+1; one write per cycle sustained.
// Backpressure: port 0 wins unless port 1 has starved STARVE_MAX cycles; rdy is low in reset.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = WB_STARVE_MAX,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   v0,
    input  logic [RFIDX_WIDTH-1:0] idx0,
    input  logic [XLEN-1:0]        data0,
    output logic                   rdy0,
    input  logic                   v1,
    input  logic [RFIDX_WIDTH-1:0] idx1,
    input  logic [XLEN-1:0]        data1,
    output logic                   rdy1,
    output logic                   we3,
    output logic [RFIDX_WIDTH-1:0] wa3,
    output logic [XLEN-1:0]        wd3,
    output logic                   starve,
    output logic [CNT_W-1:0]       wb_cnt
);

    wb_req_t req0;
    wb_req_t req1;
    wb_req_t sel;
    logic    accept;

    assign req0 = '{idx: idx0, data: data0};
    assign req1 = '{idx: idx1, data: data1};

    rf_wb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rstn   (rstn),
        .v1     (v1),
        .rdy1   (rdy1),
        .starve (starve)
    );

    // Port 0 has priority except when port 1 is starving; nothing is granted in reset
    always_comb begin
        rdy0 = rstn & v0 & ~starve;
        rdy1 = rstn & v1 & (~v0 | starve);
    end

    // Route the granted request to the output stage
    always_comb begin
        sel    = req0;
        accept = rdy0 | rdy1;
        if (rdy1) begin
            sel = req1;
        end
    end

    // Output stage: x0 writes are accepted but never reach the regfile
    always_ff @(posedge clk) begin
        if (!rstn) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= accept & (sel.idx != '0);
            if (accept) begin
                wa3 <= sel.idx;
                wd3 <= sel.data;
            end
        end
    end

    // Count regfile writes actually issued; wraps naturally
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_cnt <= '0;
        end else if (we3) begin
            wb_cnt <= wb_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rstn;
    logic        v0;
    logic [4:0]  idx0;
    logic [31:0] data0;
    logic        rdy0;
    logic        v1;
    logic [4:0]  idx1;
    logic [31:0] data1;
    logic        rdy1;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        starve;
    logic [31:0] wb_cnt;

    int tests;
    int errs;

    logic [31:0] rf [32];

    rf_wb_arbiter #(
        .STARVE_MAX (4),
        .CNT_W      (32)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .v0     (v0),
        .idx0   (idx0),
        .data0  (data0),
        .rdy0   (rdy0),
        .v1     (v1),
        .idx1   (idx1),
        .data1  (data1),
        .rdy1   (rdy1),
        .we3    (we3),
        .wa3    (wa3),
        .wd3    (wd3),
        .starve (starve),
        .wb_cnt (wb_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple regfile that commits on the falling edge, as the real one does
    always @(negedge clk) begin
        if (we3 === 1'b1) rf[wa3] <= wd3;
    end

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        v0 = 1'b1; idx0 = 5'd1; data0 = 32'hAA;
        v1 = 1'b1; idx1 = 5'd2; data1 = 32'hBB;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            tests++;
            if (we3 !== 1'b0 || wa3 !== 5'd0 || wd3 !== 32'd0 || wb_cnt !== 32'd0) begin
                errs++;
                $display("FAIL reset_regs: we3=%b wa3=%0d wd3=%h wb_cnt=%0d, want 0/0/0/0", we3, wa3, wd3, wb_cnt);
            end
            @(negedge clk);
            tests++;
            if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
                errs++;
                $display("FAIL reset_rdy: rdy0=%b rdy1=%b, want 0 0", rdy0, rdy1);
            end
        end
        next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        tests++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0 || starve !== 1'b0) begin
            errs++;
            $display("FAIL release_grant: rdy0=%b rdy1=%b starve=%b, want 1 0 0", rdy0, rdy1, starve);
        end
        next_cycle();
        v0 = 1'b0; v1 = 1'b0;
        tests++;
        if (we3 !== 1'b1 || wa3 !== 5'd1 || wd3 !== 32'hAA) begin
            errs++;
            $display("FAIL release_write: we3=%b wa3=%0d wd3=%h, want 1 1 000000aa", we3, wa3, wd3);
        end
        next_cycle();
        tests++;
        if (wb_cnt !== 32'd1 || we3 !== 1'b0) begin
            errs++;
            $display("FAIL release_cnt: wb_cnt=%0d we3=%b, want 1 0", wb_cnt, we3);
        end
    endtask

    task automatic test_single_write();
        v0 = 1'b1; idx0 = 5'd5; data0 = 32'hDEADBEEF;
        @(negedge clk);
        tests++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
            errs++;
            $display("FAIL single_rdy: rdy0=%b rdy1=%b, want 1 0", rdy0, rdy1);
        end
        next_cycle();
        v0 = 1'b0;
        tests++;
        if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 32'hDEADBEEF || wb_cnt !== 32'd1) begin
            errs++;
            $display("FAIL single_out: we3=%b wa3=%0d wd3=%h wb_cnt=%0d, want 1 5 deadbeef 1", we3, wa3, wd3, wb_cnt);
        end
        next_cycle();
        tests++;
        if (we3 !== 1'b0 || wa3 !== 5'd5 || wb_cnt !== 32'd2) begin
            errs++;
            $display("FAIL single_after: we3=%b wa3=%0d wb_cnt=%0d, want 0 5 2", we3, wa3, wb_cnt);
        end
    endtask

    task automatic test_x0();
        v1 = 1'b1; idx1 = 5'd0; data1 = 32'h1234;
        @(negedge clk);
        tests++;
        if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
            errs++;
            $display("FAIL x0_rdy: rdy1=%b rdy0=%b, want 1 0", rdy1, rdy0);
        end
        next_cycle();
        v1 = 1'b0;
        tests++;
        if (we3 !== 1'b0 || wa3 !== 5'd0 || wd3 !== 32'h1234) begin
            errs++;
            $display("FAIL x0_out: we3=%b wa3=%0d wd3=%h, want 0 0 00001234", we3, wa3, wd3);
        end
        next_cycle();
        tests++;
        if (wb_cnt !== 32'd2 || rf[0] !== 32'd0) begin
            errs++;
            $display("FAIL x0_cnt: wb_cnt=%0d rf0=%h, want 2 0", wb_cnt, rf[0]);
        end
    endtask

    task automatic test_starve();
        v0 = 1'b1; idx0 = 5'd4; data0 = 32'h40;
        v1 = 1'b1; idx1 = 5'd7; data1 = 32'h77;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (rdy1 !== 1'b0 || rdy0 !== 1'b1 || starve !== 1'b0) begin
                errs++;
                $display("FAIL starve_wait%0d: rdy1=%b rdy0=%b starve=%b, want 0 1 0", c, rdy1, rdy0, starve);
            end
            next_cycle();
        end
        @(negedge clk);
        tests++;
        if (starve !== 1'b1 || rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
            errs++;
            $display("FAIL starve_grant: starve=%b rdy1=%b rdy0=%b, want 1 1 0", starve, rdy1, rdy0);
        end
        next_cycle();
        idx1 = 5'd8; data1 = 32'h88;
        tests++;
        if (we3 !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'h77) begin
            errs++;
            $display("FAIL starve_write: we3=%b wa3=%0d wd3=%h, want 1 7 00000077", we3, wa3, wd3);
        end
        @(negedge clk);
        tests++;
        if (starve !== 1'b0 || rdy1 !== 1'b0 || rdy0 !== 1'b1) begin
            errs++;
            $display("FAIL starve_cleared: starve=%b rdy1=%b rdy0=%b, want 0 0 1", starve, rdy1, rdy0);
        end
        next_cycle();
        v0 = 1'b0; v1 = 1'b0;
        next_cycle();
        tests++;
        if (wb_cnt !== 32'd8) begin
            errs++;
            $display("FAIL starve_cnt: wb_cnt=%0d, want 8", wb_cnt);
        end
    endtask

    task automatic test_back_to_back();
        v0 = 1'b1; idx0 = 5'd3; data0 = 32'd1;
        @(negedge clk);
        tests++;
        if (rdy0 !== 1'b1) begin
            errs++;
            $display("FAIL b2b_rdy0: rdy0=%b, want 1", rdy0);
        end
        next_cycle();
        v0 = 1'b0;
        v1 = 1'b1; idx1 = 5'd3; data1 = 32'd2;
        tests++;
        if (we3 !== 1'b1 || wa3 !== 5'd3 || wd3 !== 32'd1) begin
            errs++;
            $display("FAIL b2b_first: we3=%b wa3=%0d wd3=%h, want 1 3 1", we3, wa3, wd3);
        end
        @(negedge clk);
        tests++;
        if (rdy1 !== 1'b1) begin
            errs++;
            $display("FAIL b2b_rdy1: rdy1=%b, want 1", rdy1);
        end
        next_cycle();
        v1 = 1'b0;
        tests++;
        if (we3 !== 1'b1 || wa3 !== 5'd3 || wd3 !== 32'd2) begin
            errs++;
            $display("FAIL b2b_second: we3=%b wa3=%0d wd3=%h, want 1 3 2", we3, wa3, wd3);
        end
        next_cycle();
        tests++;
        if (rf[3] !== 32'd2 || wb_cnt !== 32'd10) begin
            errs++;
            $display("FAIL b2b_rf: rf3=%h wb_cnt=%0d, want 2 10", rf[3], wb_cnt);
        end
    endtask

    task automatic test_mid_reset();
        v0 = 1'b1; idx0 = 5'd9; data0 = 32'h99;
        @(negedge clk);
        tests++;
        if (rdy0 !== 1'b1) begin
            errs++;
            $display("FAIL midrst_rdy: rdy0=%b, want 1", rdy0);
        end
        #1;
        rstn = 1'b0;
        next_cycle();
        v0 = 1'b0;
        rstn = 1'b1;
        tests++;
        if (we3 !== 1'b0 || wb_cnt !== 32'd0) begin
            errs++;
            $display("FAIL midrst_out: we3=%b wb_cnt=%0d, want 0 0", we3, wb_cnt);
        end
        next_cycle();
        tests++;
        if (rf[9] !== 32'd0 || we3 !== 1'b0) begin
            errs++;
            $display("FAIL midrst_rf: rf9=%h we3=%b, want 0 0", rf[9], we3);
        end
    endtask

    initial begin
        tests = 0;
        errs  = 0;
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        rstn = 1'b0;
        v0 = 1'b0; idx0 = 5'd0; data0 = 32'd0;
        v1 = 1'b0; idx1 = 5'd0; data1 = 32'd0;
        test_reset();
        test_single_write();
        test_x0();
        test_starve();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
